// File: rtl/scanline_pair_buffer.sv
// Collects N_LINES x ROW_WIDTH RGB pixels into a block and presents it with the previous block.
// Define SCANLINE_PAIR_BUFFER_EOL_CHECK_EN to enable s_eol line-length checking and the eol_err pulse.
module scanline_pair_buffer #(
    parameter int BIT_DEPTH = 8,
    parameter int ROW_WIDTH = 2,
    parameter int N_LINES   = 2
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [2:0][BIT_DEPTH-1:0]                              s_pixel,
    input  logic                                                   s_valid,
    output logic                                                   s_ready,
    input  logic                                                   s_sof,
    input  logic                                                   s_eol,
    output logic [N_LINES-1:0][ROW_WIDTH-1:0][2:0][BIT_DEPTH-1:0] scanline_in_last,
    output logic [N_LINES-1:0][ROW_WIDTH-1:0][2:0][BIT_DEPTH-1:0] scanline_in_current,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic                                                   eol_err
);

    localparam int CW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int LW = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(ROW_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(N_LINES - 1);

    typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;
    typedef logic [N_LINES-1:0][ROW_WIDTH-1:0][2:0][BIT_DEPTH-1:0] block_t;

    state_t        state_r;
    logic [CW-1:0] col_r;
    logic [LW-1:0] line_r;
    logic          first_r;
    block_t        fill_r;

    logic          accept_s;
    logic          stage_free_s;
    logic [CW-1:0] base_col_s;
    logic [LW-1:0] base_line_s;
    logic          eol_bad_s;
    logic          write_s;
    logic          block_done_s;
    logic          first_s;
    logic          commit_s;
    block_t        fill_upd_s;

    assign s_ready = (state_r == FILL) && !rst;

    // Accept decode, line-length check, fill update and commit decision.
    always_comb begin
        accept_s     = s_valid && s_ready;
        stage_free_s = !out_valid || out_ready;
        // An accepted start-of-frame pixel always lands at the block origin.
        if (accept_s && s_sof) begin
            base_col_s  = '0;
            base_line_s = '0;
        end else begin
            base_col_s  = col_r;
            base_line_s = line_r;
        end
`ifdef SCANLINE_PAIR_BUFFER_EOL_CHECK_EN
        eol_bad_s = accept_s && (s_eol != (base_col_s == COL_LAST));
`else
        eol_bad_s = s_eol & 1'b0;
`endif
        write_s      = accept_s && !eol_bad_s;
        block_done_s = write_s && (base_col_s == COL_LAST) && (base_line_s == LINE_LAST);
        first_s      = first_r || (accept_s && s_sof);
        fill_upd_s   = fill_r;
        if (write_s) begin
            fill_upd_s[base_line_s][base_col_s] = s_pixel;
        end else begin
            fill_upd_s = fill_r;
        end
        case (state_r)
            FILL:    commit_s = block_done_s && stage_free_s;
            WAIT:    commit_s = stage_free_s;
            default: commit_s = 1'b0;
        endcase
    end

    // Counters, fill storage, output pair, handshake state and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r             <= FILL;
            col_r               <= '0;
            line_r              <= '0;
            first_r             <= 1'b1;
            fill_r              <= '0;
            scanline_in_last    <= '0;
            scanline_in_current <= '0;
            out_valid           <= 1'b0;
            eol_err             <= 1'b0;
        end else begin
            eol_err <= eol_bad_s;
            fill_r  <= fill_upd_s;

            if (write_s) begin
                if (base_col_s == COL_LAST) begin
                    col_r  <= '0;
                    line_r <= (base_line_s == LINE_LAST) ? '0 : base_line_s + 1'b1;
                end else begin
                    col_r  <= base_col_s + 1'b1;
                    line_r <= base_line_s;
                end
            end else if (eol_bad_s) begin
                col_r  <= '0;
                line_r <= base_line_s;
            end else begin
                col_r  <= col_r;
                line_r <= line_r;
            end

            // After reset or a new frame both halves get the same block so nothing stale is blended.
            if (commit_s) begin
                scanline_in_current <= fill_upd_s;
                scanline_in_last    <= first_s ? fill_upd_s : scanline_in_current;
                first_r             <= 1'b0;
                out_valid           <= 1'b1;
            end else begin
                first_r   <= first_s;
                out_valid <= out_valid && !out_ready;
            end

            case (state_r)
                FILL:    state_r <= (block_done_s && !stage_free_s) ? WAIT : FILL;
                WAIT:    state_r <= stage_free_s ? FILL : WAIT;
                default: state_r <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_scanline_pair_buffer.sv
// Self-checking bench for scanline_pair_buffer: directed scenarios plus randomized traffic
// against a block-level reference model; honours SCANLINE_PAIR_BUFFER_EOL_CHECK_EN.
module tb_scanline_pair_buffer;

    localparam int BD = 8;
    localparam int R  = 2;
    localparam int N  = 2;
    localparam int BW = N * R * 3 * BD;
`ifdef SCANLINE_PAIR_BUFFER_EOL_CHECK_EN
    localparam bit EOL_EN = 1'b1;
`else
    localparam bit EOL_EN = 1'b0;
`endif

    typedef logic [2:0][BD-1:0] pix_t;
    typedef logic [N-1:0][R-1:0][2:0][BD-1:0] blk_t;

    logic clk;
    logic rst;
    pix_t s_pixel;
    logic s_valid;
    logic s_ready;
    logic s_sof;
    logic s_eol;
    blk_t scanline_in_last;
    blk_t scanline_in_current;
    logic out_valid;
    logic out_ready;
    logic eol_err;

    int errors = 0;
    int checks = 0;

    // Reference model: linear fill position, pending-block flag and the presented pair.
    blk_t m_fill, m_last, m_cur;
    int   m_pos = 0;
    bit   m_first = 1'b1, m_ov = 1'b0, m_err = 1'b0, m_blocked = 1'b0, m_acc = 1'b0;
    bit   chk_on = 1'b0;

    scanline_pair_buffer #(.BIT_DEPTH(BD), .ROW_WIDTH(R), .N_LINES(N)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_pixel             (s_pixel),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .s_sof               (s_sof),
        .s_eol               (s_eol),
        .scanline_in_last    (scanline_in_last),
        .scanline_in_current (scanline_in_current),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .eol_err             (eol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pix_t rgb(input int r, input int g, input int b);
        pix_t p;
        p[0] = r[BD-1:0];
        p[1] = g[BD-1:0];
        p[2] = b[BD-1:0];
        return p;
    endfunction

    function automatic blk_t solid(input pix_t p);
        blk_t b;
        for (int l = 0; l < N; l++)
            for (int c = 0; c < R; c++)
                b[l][c] = p;
        return b;
    endfunction

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_update();
        bit free;
        bit done;
        done = 1'b0;
        if (rst) begin
            m_fill = '0; m_last = '0; m_cur = '0;
            m_pos = 0; m_first = 1'b1; m_ov = 1'b0; m_err = 1'b0;
            m_blocked = 1'b0; m_acc = 1'b0;
        end else begin
            m_acc = s_valid && !m_blocked;
            free  = !m_ov || out_ready;
            m_err = 1'b0;
            if (m_acc) begin
                if (s_sof) begin
                    m_pos   = 0;
                    m_first = 1'b1;
                end
                if (EOL_EN && (s_eol != ((m_pos % R) == R - 1))) begin
                    m_err = 1'b1;
                    m_pos = m_pos - (m_pos % R);
                end else begin
                    m_fill[m_pos / R][m_pos % R] = s_pixel;
                    m_pos++;
                    if (m_pos == R * N) begin
                        m_pos = 0;
                        done  = 1'b1;
                    end
                end
            end
            if ((done || m_blocked) && free) begin
                m_last    = m_first ? m_fill : m_cur;
                m_cur     = m_fill;
                m_first   = 1'b0;
                m_ov      = 1'b1;
                m_blocked = 1'b0;
            end else begin
                if (done) m_blocked = 1'b1;
                m_ov = m_ov && !out_ready;
            end
        end
        chk_on = 1'b1;
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("s_ready",   BW'(s_ready),   BW'(!rst && !m_blocked));
            check("out_valid", BW'(out_valid), BW'(m_ov));
            check("eol_err",   BW'(eol_err),   BW'(m_err));
            check("last",      scanline_in_last,    m_last);
            check("current",   scanline_in_current, m_cur);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input pix_t p, input bit sof, input bit bad);
        int n;
        n = 0;
        s_pixel = p;
        s_sof   = sof;
        s_valid = 1'b1;
        s_eol   = ((((sof ? 0 : m_pos) % R) == R - 1) ? 1'b1 : 1'b0) ^ bad;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 50);
        checks++;
        if (!m_acc) begin
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    pix_t white, black, red, green, grey, blue, yellow, cyan, magenta, orange;

    initial begin
        white   = rgb(255, 255, 255);
        black   = rgb(0, 0, 0);
        red     = rgb(255, 0, 0);
        green   = rgb(0, 255, 0);
        grey    = rgb(127, 127, 127);
        blue    = rgb(0, 0, 255);
        yellow  = rgb(255, 255, 0);
        cyan    = rgb(0, 255, 255);
        magenta = rgb(255, 0, 255);
        orange  = rgb(255, 128, 0);

        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        s_pixel = '0; out_ready = 1'b0;
        idle(2);
        check("rst_out_valid", BW'(out_valid), BW'(0));
        check("rst_s_ready",   BW'(s_ready),   BW'(0));
        check("rst_current",   scanline_in_current, '0);
        rst = 1'b0;
        idle(1);
        check("post_rst_s_ready", BW'(s_ready), BW'(1));

        // Four white pixels: pair appears the cycle after the fourth accept.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(white, 1'b0, 1'b0);
        check("white_not_yet", BW'(out_valid), BW'(0));
        send(white, 1'b0, 1'b0);
        check("white_valid",   BW'(out_valid), BW'(1));
        check("white_last",    scanline_in_last,    solid(white));
        check("white_current", scanline_in_current, solid(white));

        // Black block follows white.
        for (int i = 0; i < 4; i++) send(black, 1'b0, 1'b0);
        check("black_last",    scanline_in_last,    solid(white));
        check("black_current", scanline_in_current, solid(black));

        // Backpressure: red commits, green waits until one out_ready cycle.
        idle(2);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(red, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(green, 1'b0, 1'b0);
        check("bp_s_ready",  BW'(s_ready), BW'(0));
        check("bp_current",  scanline_in_current, solid(red));
        check("bp_last",     scanline_in_last,    solid(black));
        s_valid = 1'b1; s_pixel = white;
        idle(2);
        s_valid = 1'b0;
        check("bp_hold_current", scanline_in_current, solid(red));
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("bp_rel_last",    scanline_in_last,    solid(red));
        check("bp_rel_current", scanline_in_current, solid(green));
        check("bp_rel_s_ready", BW'(s_ready), BW'(1));

        // Start of frame discards the partial grey block.
        out_ready = 1'b1;
        idle(2);
        for (int i = 0; i < 3; i++) send(grey, 1'b0, 1'b0);
        send(blue, 1'b1, 1'b0);
        send(blue, 1'b0, 1'b0);
        send(blue, 1'b0, 1'b0);
        check("sof_no_commit", BW'(out_valid), BW'(0));
        send(blue, 1'b0, 1'b0);
        check("sof_valid",   BW'(out_valid), BW'(1));
        check("sof_last",    scanline_in_last,    solid(blue));
        check("sof_current", scanline_in_current, solid(blue));

        // Wrong s_eol on column 0.
        idle(2);
        send(yellow, 1'b1, 1'b1);
        check("eol_err_pulse", BW'(eol_err), BW'(EOL_EN));
        idle(1);
        check("eol_err_clear", BW'(eol_err), BW'(0));
        send(cyan, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(cyan, 1'b0, 1'b0);
        check("eol_current", scanline_in_current, solid(cyan));
        check("eol_last",    scanline_in_last,    solid(cyan));

        // Reset mid-block with an unconsumed pair pending.
        out_ready = 1'b0;
        send(magenta, 1'b0, 1'b0);
        send(magenta, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        check("midrst_s_ready",   BW'(s_ready),   BW'(0));
        check("midrst_out_valid", BW'(out_valid), BW'(0));
        check("midrst_last",      scanline_in_last,    '0);
        check("midrst_current",   scanline_in_current, '0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(orange, 1'b0, 1'b0);
        check("midrst_new_last",    scanline_in_last,    solid(orange));
        check("midrst_new_current", scanline_in_current, solid(orange));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            s_valid   = ($urandom_range(0, 3) != 0);
            s_pixel   = pix_t'($urandom);
            s_sof     = ($urandom_range(0, 29) == 0);
            s_eol     = ((((s_sof ? 0 : m_pos) % R) == R - 1) ? 1'b1 : 1'b0)
                        ^ ($urandom_range(0, 19) == 0);
            out_ready = (i % 500 < 250) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; s_valid = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
